// File: rtl/fwd_sel_ctrl_pkg.sv
// rtl/fwd_sel_ctrl_pkg.sv - shared select codes and priority helper for EX forwarding
//
// Purpose: select encodings shared with the EX operand muxes, plus the
//          younger-producer-wins select picker used by fwd_sel_ctrl.
// Macros defined here (shared with the operand muxes):
//   FWD_SEL_RF, FWD_SEL_MEM, FWD_SEL_WB, FWD_SEL_WIDTH
`ifndef FWD_SEL_DEFS
`define FWD_SEL_DEFS
`define FWD_SEL_RF    2'b00
`define FWD_SEL_MEM   2'b01
`define FWD_SEL_WB    2'b10
`define FWD_SEL_WIDTH 2
`endif

package fwd_sel_ctrl_pkg;

  // Mux input order of the EX operand muxes; 2'b11 is never produced.
  typedef enum logic [`FWD_SEL_WIDTH-1:0] {
    SEL_RF  = `FWD_SEL_RF,
    SEL_MEM = `FWD_SEL_MEM,
    SEL_WB  = `FWD_SEL_WB
  } fwd_sel_e;

  // Select seen by the ID instruction once it reaches EX: a producer now in
  // EX will sit in MEM, one now in MEM will sit in WB. Younger wins.
  function automatic fwd_sel_e pick_sel(input logic ex_hit, input logic mem_hit);
    if (ex_hit) begin
      return SEL_MEM;
    end else if (mem_hit) begin
      return SEL_WB;
    end else begin
      return SEL_RF;
    end
  endfunction

endpackage

// File: rtl/fwd_sel_ctrl_match.sv
// rtl/fwd_sel_ctrl_match.sv - producer/reader register match comparator
//
// Purpose: flags that a pipeline stage produces the register an ID source reads.
// Ports:
//   we_i      - stage writes its rd
//   rd_i      - stage destination index
//   rs_i      - ID source index
//   rs_used_i - ID instruction actually reads rs
//   hit_o     - forwarding candidate (never for x0)
module fwd_match #(
  parameter int W = 5
) (
  input  logic         we_i,
  input  logic [W-1:0] rd_i,
  input  logic [W-1:0] rs_i,
  input  logic         rs_used_i,
  output logic         hit_o
);

  // x0 reads are hard-wired zero, so a write to x0 is never forwarded.
  assign hit_o = we_i && rs_used_i && (rd_i == rs_i) && (rs_i != '0);

endmodule

// File: rtl/fwd_sel_ctrl.sv
// rtl/fwd_sel_ctrl.sv - EX operand forwarding select and load-use stall controller
//
// Purpose: shadows rd/we/is_load of the EX, MEM (and WB) instructions, computes
//          registered operand selects for the instruction entering EX, and
//          raises a combinational load-use stall.
// Optional macro: FWD_RF_BYPASS_EN adds id_bypass_a_o/id_bypass_b_o (WB match
//          against ID sources, for a regfile read-bypass mux).
// Ports:
//   clk_i, rst_n_i         - clock, asynchronous active-low reset
//   id_valid_i             - ID holds a real instruction
//   id_rs1_i/id_rs2_i      - ID source indices, with id_rs1_used_i/id_rs2_used_i
//   id_rd_i/id_we_i        - ID destination and write enable
//   id_is_load_i           - ID instruction is a load
//   pipe_hold_i            - global freeze
//   flush_i                - kill the ID instruction
//   stall_id_o             - load-use stall (hold PC and IF/ID)
//   ex_fwd_sel_a_o/_b_o    - registered EX operand mux selects
module fwd_sel_ctrl
  import fwd_sel_ctrl_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      id_valid_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2_i,
  input  logic                      id_rs1_used_i,
  input  logic                      id_rs2_used_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd_i,
  input  logic                      id_we_i,
  input  logic                      id_is_load_i,
  input  logic                      pipe_hold_i,
  input  logic                      flush_i,
  output logic                      stall_id_o,
  output logic [`FWD_SEL_WIDTH-1:0] ex_fwd_sel_a_o,
`ifdef FWD_RF_BYPASS_EN
  output logic                      id_bypass_a_o,
  output logic                      id_bypass_b_o,
`endif
  output logic [`FWD_SEL_WIDTH-1:0] ex_fwd_sel_b_o
);

  localparam int W = REG_ADDR_WIDTH;

  logic         ex_we_q,   ex_we_d;
  logic         ex_load_q, ex_load_d;
  logic [W-1:0] ex_rd_q,   ex_rd_d;
  logic         mem_we_q;
  logic [W-1:0] mem_rd_q;
  fwd_sel_e     sel_a_q,   sel_a_d;
  fwd_sel_e     sel_b_q,   sel_b_d;

  logic ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
  logic issue;

  fwd_match #(.W(W)) u_ex_a  (.we_i(ex_we_q),  .rd_i(ex_rd_q),  .rs_i(id_rs1_i),
                              .rs_used_i(id_rs1_used_i), .hit_o(ex_hit_a));
  fwd_match #(.W(W)) u_ex_b  (.we_i(ex_we_q),  .rd_i(ex_rd_q),  .rs_i(id_rs2_i),
                              .rs_used_i(id_rs2_used_i), .hit_o(ex_hit_b));
  fwd_match #(.W(W)) u_mem_a (.we_i(mem_we_q), .rd_i(mem_rd_q), .rs_i(id_rs1_i),
                              .rs_used_i(id_rs1_used_i), .hit_o(mem_hit_a));
  fwd_match #(.W(W)) u_mem_b (.we_i(mem_we_q), .rd_i(mem_rd_q), .rs_i(id_rs2_i),
                              .rs_used_i(id_rs2_used_i), .hit_o(mem_hit_b));

  // A load still in EX has no result to forward yet; flush kills the reader,
  // so it cannot stall.
  assign stall_id_o = id_valid_i && !flush_i && ex_load_q && (ex_hit_a || ex_hit_b);

  // Only a live, unflushed, unstalled instruction enters EX; anything else is a bubble.
  assign issue = id_valid_i && !flush_i && !stall_id_o;

  always_comb begin
    ex_we_d   = 1'b0;
    ex_load_d = 1'b0;
    ex_rd_d   = '0;
    sel_a_d   = SEL_RF;
    sel_b_d   = SEL_RF;
    if (issue) begin
      ex_we_d   = id_we_i;
      ex_load_d = id_is_load_i;
      ex_rd_d   = id_rd_i;
      sel_a_d   = pick_sel(ex_hit_a, mem_hit_a);
      sel_b_d   = pick_sel(ex_hit_b, mem_hit_b);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ex_we_q   <= 1'b0;
      ex_load_q <= 1'b0;
      ex_rd_q   <= '0;
      mem_we_q  <= 1'b0;
      mem_rd_q  <= '0;
      sel_a_q   <= SEL_RF;
      sel_b_q   <= SEL_RF;
    end else if (!pipe_hold_i) begin
      ex_we_q   <= ex_we_d;
      ex_load_q <= ex_load_d;
      ex_rd_q   <= ex_rd_d;
      mem_we_q  <= ex_we_q;
      mem_rd_q  <= ex_rd_q;
      sel_a_q   <= sel_a_d;
      sel_b_q   <= sel_b_d;
    end
  end

  assign ex_fwd_sel_a_o = sel_a_q;
  assign ex_fwd_sel_b_o = sel_b_q;

`ifdef FWD_RF_BYPASS_EN
  // WB shadow is only needed to cover the same-cycle regfile write/read case.
  logic         wb_we_q;
  logic [W-1:0] wb_rd_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wb_we_q <= 1'b0;
      wb_rd_q <= '0;
    end else if (!pipe_hold_i) begin
      wb_we_q <= mem_we_q;
      wb_rd_q <= mem_rd_q;
    end
  end

  fwd_match #(.W(W)) u_wb_a (.we_i(wb_we_q), .rd_i(wb_rd_q), .rs_i(id_rs1_i),
                             .rs_used_i(id_rs1_used_i), .hit_o(id_bypass_a_o));
  fwd_match #(.W(W)) u_wb_b (.we_i(wb_we_q), .rd_i(wb_rd_q), .rs_i(id_rs2_i),
                             .rs_used_i(id_rs2_used_i), .hit_o(id_bypass_b_o));
`endif

endmodule

// File: doc/fwd_sel_ctrl.md
Name: fwd_sel_ctrl

Overview:
- Pipeline-side producer of the 2-bit operand-select codes consumed by the 3-input operand muxes in EX.
- Tracks the destination register of the in-flight EX, MEM and WB instructions in shadow registers.
- Each cycle it computes forwarding selects for the instruction in ID, registers them into EX, and raises a load-use stall when forwarding cannot cover a hazard.
- Sits beside the ID/EX pipeline register in the RV32I core.

Parameters:
REG_ADDR_WIDTH, 5, register index width (x0..x31)

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_rs1  in  REG_ADDR_WIDTH  ID source 1 index
id_rs2  in  REG_ADDR_WIDTH  ID source 2 index
id_rs1_used  in  1  instruction reads rs1
id_rs2_used  in  1  instruction reads rs2
id_rd  in  REG_ADDR_WIDTH  ID destination index
id_we  in  1  instruction writes rd
id_is_load  in  1  instruction is a load
pipe_hold  in  1  global freeze (e.g. memory wait)
flush  in  1  kill ID instruction (taken branch resolved in EX)
stall_id  out  1  combinational load-use stall; hold PC and IF/ID
ex_fwd_sel_a  out  2  registered select for EX operand A mux
ex_fwd_sel_b  out  2  registered select for EX operand B mux

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous, active-low.
- Select encoding (mux input order):
  - 2'b00 regfile value
  - 2'b01 MEM-stage result
  - 2'b10 WB-stage result
  - 2'b11 never driven
- Reset:
  - All shadow valid/we bits clear; shadow rd = 0.
  - ex_fwd_sel_a/b = 2'b00; stall_id = 0.
  - Reset mid-operation discards all tracking immediately.
- Shadow pipeline, advancing on each rising edge when pipe_hold = 0:
  - EX fields <- ID inputs, gated: entry is a bubble (we = 0, is_load = 0) if id_valid = 0, flush = 1, or stall_id = 1.
  - MEM fields <- EX fields; WB fields <- MEM fields.
- "Producer match" for stage S and source rs: S.we && S.rd == rs && rs != 0 && rs_used. x0 is never forwarded.
- Select computation in ID, applied to EX on the next edge:
  - If the current EX stage matches → 2'b01 (it will be in MEM).
  - Else if the current MEM stage matches → 2'b10 (it will be in WB).
  - Else → 2'b00. The younger producer always wins.
- Latency: selects are registered, valid from the first cycle the instruction occupies EX. No combinational path from inputs to ex_fwd_sel_*.
- Load-use stall:
  - stall_id = id_valid && !flush && EX.is_load && EX.we && (rs1 match || rs2 match).
  - During the stall the EX entry is a bubble with sel = 00. On the following cycle the load is in MEM, so the dependent instruction gets sel = 10.
  - Exactly one stall cycle per load-use pair.
- pipe_hold = 1:
  - All shadow registers and ex_fwd_sel_* hold their values.
  - stall_id is still evaluated from the held state.
  - Priority order: reset > pipe_hold > flush > stall_id > normal advance.
- flush = 1 (with pipe_hold = 0):
  - The entry into EX becomes a bubble with selects 00.
  - EX/MEM/WB producers still advance, so older instructions complete.
- Simultaneous flush and load-use stall: flush wins, and stall_id = 0.
- WB producer vs ID reader in the same cycle is not handled here; see the optional feature.

Optional Feature:
FWD_RF_BYPASS_EN
- Defined:
  - Adds outputs id_bypass_a and id_bypass_b (1 bit each, combinational).
  - Each is asserted when the WB stage matches the corresponding ID source (same match rule), driving a regfile read-bypass mux.
- Undefined:
  - Ports absent; the register file is write-first and covers this case.
- No other behaviour changes.

Decomposition:
- include.v: `define FWD_SEL_RF 2'b00, FWD_SEL_MEM 2'b01, FWD_SEL_WB 2'b10, FWD_SEL_WIDTH 2. The operand muxes and this block share these.
- One sub-module, fwd_match: a combinational comparator (we, rd, rs, rs_used → hit), instantiated per stage/source pair.

Test Plan:
- Back-to-back ALU: add x5 then sub x6,x5,x1 → second instruction in EX has sel_a = 01, sel_b = 00, stall_id = 0.
- Distance two: add x5; nop; or x7,x5,x5 → sel_a = sel_b = 10.
- Load-use: lw x8 then add x9,x8,x2 → stall_id = 1 for exactly 1 cycle, bubble in EX with sel 00, then the add in EX has sel_a = 10.
- x0 writer: addi x0 then add x3,x0,x0 → selects 00, no stall.
- flush while stall condition present → stall_id = 0, EX bubble with sel 00.
- Hold and reset:
  - pipe_hold = 1 for 3 cycles mid-sequence → selects and shadow state frozen, resume correctly.
  - rst_n pulled low mid-stall → all outputs 0 asynchronously.
